barrel_thread_scheduler: RTL and testbench

//  Slot sequencer for the barrel core. Rotates the active thread ID one step per cycle, strictly

---
 rtl/barrel_thread_scheduler.sv | 131 +++++++++++++
 tb/tb_barrel_thread_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_thread_scheduler.sv
// Barrel core slot sequencer: strict round-robin thread rotation for the
// multithreaded register file, per-slot issue validity, a writeback valid
// delay line with per-thread kill, and run/drain control.
module barrel_thread_scheduler #(
    parameter  int unsigned NUM_THREADS  = 8,
    parameter  int unsigned PIPE_DEPTH   = 5,
    localparam int unsigned BITS_THREADS = $clog2(NUM_THREADS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic [NUM_THREADS-1:0]  thread_enable,
    input  logic [NUM_THREADS-1:0]  thread_stall,
    input  logic                    kill_valid,
    input  logic [BITS_THREADS-1:0] kill_tid,
    output logic [BITS_THREADS-1:0] tid_read,
    output logic                    issue_valid,
    output logic [BITS_THREADS-1:0] tid_write,
    output logic                    wb_valid,
    output logic                    busy,
    output logic [31:0]             issue_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Writeback slot trails the issue slot by the pipeline depth, mod thread count.
    localparam logic [BITS_THREADS-1:0] DEPTH_MOD = BITS_THREADS'(PIPE_DEPTH);

    state_t                state;
    state_t                state_next;

    // v[k] is the valid bit of the instruction issued k cycles ago,
    // owned by thread (tid_read - k) mod NUM_THREADS.
    logic [PIPE_DEPTH:1]   v;
    logic [PIPE_DEPTH:1]   v_next;

    logic                  kill_here;
    logic                  pipe_empty;

    assign tid_write  = tid_read - DEPTH_MOD;
    assign wb_valid   = v[PIPE_DEPTH];
    assign busy       = (state != ST_IDLE);
    assign pipe_empty = (v == '0);
    assign kill_here  = kill_valid & (kill_tid == tid_read);

    // Issue qualification for the thread owning the current slot.
    always_comb begin
        issue_valid = (state == ST_RUN)
                    & thread_enable[tid_read]
                    & ~thread_stall[tid_read]
                    & ~kill_here;
    end

    // FSM next-state: start launches, stop drains, drain ends when the pipe is empty.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // New slot enters the delay line already qualified against kill.
    assign v_next[1] = issue_valid;

    // Shift the delay line; an entry whose owning thread is being killed is dropped.
    for (genvar k = 2; k <= PIPE_DEPTH; k++) begin : g_shift
        localparam logic [BITS_THREADS-1:0] AGE = BITS_THREADS'(k - 1);
        logic [BITS_THREADS-1:0] owner;
        assign owner     = tid_read - AGE;
        assign v_next[k] = v[k-1] & ~(kill_valid & (kill_tid == owner));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Rotation never stalls; the copy-back relies on every slot being visited in order.
    always_ff @(posedge clk) begin
        if (reset) begin
            tid_read <= '0;
        end else begin
            tid_read <= tid_read + BITS_THREADS'(1);
        end
    end

    // Writeback valid delay line; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
        end else begin
            v <= v_next;
        end
    end

    // Free-running count of issued instructions, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_count <= '0;
        end else if (issue_valid) begin
            issue_count <= issue_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_barrel_thread_scheduler.sv
// Directed bench for barrel_thread_scheduler with a queue scoreboard of
// in-flight slots that predicts tid_write and wb_valid every cycle.
module tb_barrel_thread_scheduler;

    localparam int N = 8;
    localparam int D = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [7:0]  thread_enable;
    logic [7:0]  thread_stall;
    logic        kill_valid;
    logic [2:0]  kill_tid;
    logic [2:0]  tid_read;
    logic        issue_valid;
    logic [2:0]  tid_write;
    logic        wb_valid;
    logic        busy;
    logic [31:0] issue_count;

    int checks = 0;
    int errors = 0;

    barrel_thread_scheduler #(
        .NUM_THREADS (N),
        .PIPE_DEPTH  (D)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .thread_enable (thread_enable),
        .thread_stall  (thread_stall),
        .kill_valid    (kill_valid),
        .kill_tid      (kill_tid),
        .tid_read      (tid_read),
        .issue_valid   (issue_valid),
        .tid_write     (tid_write),
        .wb_valid      (wb_valid),
        .busy          (busy),
        .issue_count   (issue_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] tid;
        logic       valid;
    } ent_t;

    // Oldest entry at the front is the one in the writeback slot.
    ent_t        sb[$];
    int          m_tid;
    int          m_st;      // 0 idle, 1 run, 2 drain
    logic [31:0] m_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ent_t e;
        sb.delete();
        for (int k = D; k >= 1; k--) begin
            e.tid   = 3'((N - k) % N);
            e.valid = 1'b0;
            sb.push_back(e);
        end
        m_tid   = 0;
        m_st    = 0;
        m_count = 32'd0;
    endtask

    // Compare all outputs against the model, advance the model, then one clock.
    task automatic tick();
        logic exp_issue;
        logic any;
        ent_t head;
        ent_t e;
        #1;
        exp_issue = (m_st == 1) && thread_enable[m_tid] && !thread_stall[m_tid]
                    && !(kill_valid && (int'(kill_tid) == m_tid));
        head = sb[0];
        chk("tid_read",    32'(tid_read),    32'(m_tid));
        chk("tid_write",   32'(tid_write),   32'(head.tid));
        chk("issue_valid", 32'(issue_valid), 32'(exp_issue));
        chk("wb_valid",    32'(wb_valid),    32'(head.valid));
        chk("busy",        32'(busy),        32'(m_st != 0));
        chk("issue_count", issue_count,      m_count);
        if (reset) begin
            model_reset();
        end else begin
            any = 1'b0;
            foreach (sb[i]) any |= sb[i].valid;
            case (m_st)
                0: if (start && !stop) m_st = 1;
                1: if (stop) m_st = 2;
                2: if (!any) m_st = 0;
                default: m_st = 0;
            endcase
            if (exp_issue) m_count = m_count + 32'd1;
            void'(sb.pop_front());
            if (kill_valid) begin
                foreach (sb[i]) if (sb[i].tid == kill_tid) sb[i].valid = 1'b0;
            end
            e.tid   = 3'(m_tid);
            e.valid = exp_issue;
            sb.push_back(e);
            m_tid = (m_tid + 1) % N;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        int g;
        reset         = 1'b1;
        start         = 1'b0;
        stop          = 1'b0;
        thread_enable = 8'h00;
        thread_stall  = 8'h00;
        kill_valid    = 1'b0;
        kill_tid      = 3'd0;
        @(posedge clk);
        @(negedge clk);
        #1;
        model_reset();

        // Reset state
        chk("rst_tid_read",    32'(tid_read),    32'd0);
        chk("rst_tid_write",   32'(tid_write),   32'd3);
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_wb_valid",    32'(wb_valid),    32'd0);
        chk("rst_busy",        32'(busy),        32'd0);
        chk("rst_issue_count", issue_count,      32'd0);
        reset = 1'b0;

        // 1: idle rotation
        repeat (20) tick();
        chk("t1_tid_read", 32'(tid_read), 32'd4);
        chk("t1_count",    issue_count,   32'd0);

        // 2: all enabled, start pulse
        thread_enable = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_busy",  32'(busy),        32'd1);
        chk("t2_issue", 32'(issue_valid), 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (i == 4) chk("t2_wb_before", 32'(wb_valid), 32'd0);
            if (i == 5) chk("t2_wb_first",  32'(wb_valid), 32'd1);
            tick();
        end
        chk("t2_count16", issue_count, 32'd16);

        // 3: only threads 0 and 2 enabled
        thread_enable = 8'h05;
        repeat (6) tick();
        repeat (16) begin
            chk("t3_issue_tid", 32'(issue_valid && tid_read != 3'd0 && tid_read != 3'd2), 32'd0);
            chk("t3_wb_tid",    32'(wb_valid && tid_write != 3'd0 && tid_write != 3'd2), 32'd0);
            tick();
        end

        // 4: thread 4 stalled for 8 cycles
        thread_enable = 8'hFF;
        thread_stall  = 8'h10;
        tick();
        repeat (7) begin
            chk("t4_bubble", 32'(issue_valid), 32'(tid_read != 3'd4));
            tick();
        end
        thread_stall = 8'h00;
        repeat (8) tick();

        // 5: kill thread 6 while tid_read is 1
        g = 0;
        while (tid_read != 3'd1 && g < 16) begin
            tick();
            g++;
        end
        chk("t5_align", 32'(tid_read), 32'd1);
        kill_valid = 1'b1;
        kill_tid   = 3'd6;
        tick();
        kill_valid = 1'b0;
        tick();
        chk("t5_kill_tw", 32'(tid_write), 32'd6);
        chk("t5_kill_wb", 32'(wb_valid),  32'd0);
        tick();
        chk("t5_next_wb", 32'(wb_valid),  32'd1);
        repeat (6) tick();

        // 6: stop with the pipe full, then drain
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t6_issue_off", 32'(issue_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("t6_wb_drain", 32'(wb_valid), 32'd1);
            tick();
        end
        chk("t6_wb_empty",  32'(wb_valid), 32'd0);
        chk("t6_busy_last", 32'(busy),     32'd1);
        tick();
        chk("t6_busy_off",  32'(busy),     32'd0);

        // start and stop together in IDLE stays idle
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("t6_both_idle", 32'(busy), 32'd0);
        tick();

        // reset during DRAIN
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        chk("t6_in_drain", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_wb",    32'(wb_valid),  32'd0);
        chk("t6_rst_busy",  32'(busy),      32'd0);
        chk("t6_rst_tid",   32'(tid_read),  32'd0);
        chk("t6_rst_tw",    32'(tid_write), 32'd3);
        chk("t6_rst_count", issue_count,    32'd0);
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
